pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Branches resolve in MEM, jr resolves in EX, j/jal resolve in ID. No forwarding path exists.
- The block generates PC and pipeline-register write/flush controls for: RAW stalls, control redirects, and a halt/drain sequence.
- It also keeps stall/flush statistics and a stall watchdog.

Parameters:
- DRAIN_CYCLES, 4: cycles in DRAIN needed to retire the instruction in ID at drain entry.
- MAX_STALL, 8: consecutive RAW-stall cycles that set HazardErr.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_WriteReg  in  5  EX destination register (post RegDst mux).
- M_RegWrite  in  1  MEM instruction writes the register file.
- M_WriteReg  in  5  MEM destination register.
- ID_Jump  in  1  j/jal decoded in ID.
- EX_Jr  in  1  jr in EX.
- PCSrc  in  1  branch taken, resolved in MEM.
- Halt  in  1  request to drain and hold the pipeline (level).
- PCWrite  out  1  PC register load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  load a bubble into IF/ID.
- IDEX_Flush  out  1  load a bubble (all control zero) into ID/EX.
- EXMEM_Flush  out  1  load a bubble into EX/MEM.
- Redirect  out  2  PC source select: 0 PC+4, 1 jump, 2 jr, 3 branch.
- Drained  out  1  pipeline empty and held.
- HazardErr  out  1  sticky watchdog flag.
- StallCount  out  32  saturating count of RAW-stall cycles.
- FlushCount  out  32  saturating count of redirect cycles.

Behaviour:
- Reset (async): state = RUN; StallCount, FlushCount, stall-run counter and drain counter = 0; HazardErr = 0.
- While Reset is high: PCWrite = 0, IFID_Write = 0, all flushes = 1, Redirect = 0, Drained = 0.
- Outputs are combinational from state and current inputs. Effects apply at the next Clk edge; latency is 0 cycles.
- RAW detection: raw = 1 if, for rs (gated by ID_UsesRs) or rt (gated by ID_UsesRt), the register is nonzero and equals EX_WriteReg with EX_RegWrite set, or equals M_WriteReg with M_RegWrite set.
  - WB is not checked; the register file writes before it is read.
  - Register 0 never stalls.
- Priority (highest first): PCSrc > EX_Jr > raw > ID_Jump > normal.
  - PCSrc: Redirect = 3, PCWrite = 1, IFID_Flush = IDEX_Flush = EXMEM_Flush = 1. This overrides raw.
  - EX_Jr: Redirect = 2, PCWrite = 1, IFID_Flush = IDEX_Flush = 1.
  - raw: PCWrite = 0, IFID_Write = 0, IDEX_Flush = 1. StallCount increments.
  - ID_Jump: Redirect = 1, PCWrite = 1, IFID_Flush = 1. The jump itself proceeds to EX.
  - normal: PCWrite = 1, IFID_Write = 1, no flushes.
- IFID_Write = 1 whenever IFID_Flush = 1; a flush is a load of a bubble.
- FlushCount increments on each cycle with Redirect != 0.
- Both counters saturate at 32'hFFFFFFFF.
- Watchdog: the stall-run counter increments on raw cycles and clears on any non-raw cycle. On reaching MAX_STALL, HazardErr sets and holds until Reset.
- FSM:
  - RUN:
    - Priority rules above apply.
    - If Halt = 1 and the cycle is neither redirect nor raw: go to DRAIN, drain counter = DRAIN_CYCLES.
  - DRAIN:
    - Defaults: PCWrite = 0, IFID_Flush = 1; the PC is held at the first unexecuted instruction.
    - raw: IFID_Write = 0, IFID_Flush = 0, IDEX_Flush = 1; drain counter holds.
    - PCSrc: PCWrite = 1, Redirect = 3, all three flushes; drain counter reloads to DRAIN_CYCLES.
    - EX_Jr: PCWrite = 1, Redirect = 2, IFID_Flush = IDEX_Flush = 1; drain counter reloads.
    - ID_Jump: PCWrite = 1, Redirect = 1; the drain counter decrements normally.
    - Otherwise the drain counter decrements. The transition to HALTED occurs on the edge where the counter goes 1 -> 0.
    - Halt dropping during DRAIN does not abort; the drain completes.
  - HALTED:
    - PCWrite = 0, IFID_Flush = 1, Drained = 1. No counters change.
    - Halt = 0: go to RUN on the next edge. Drained falls in the same cycle Halt is seen low.

Test Plan:
- lw $2 in EX (EX_RegWrite = 1, EX_WriteReg = 2), ID add reads rs = 2 -> 2 cycles of PCWrite = 0 / IDEX_Flush = 1 (EX match, then MEM match), then normal; StallCount = 2.
- ID_Rs = 0 with EX_WriteReg = 0, EX_RegWrite = 1 -> no stall; PCWrite = 1.
- PCSrc = 1 in the same cycle as raw = 1 and EX_Jr = 1 -> Redirect = 3, all three flushes, PCWrite = 1; StallCount unchanged, FlushCount + 1.
- Force raw for 8 consecutive cycles -> HazardErr = 1 on cycle 8 and still 1 after raw clears; only Reset clears it.
- Halt asserted in RUN with no hazard -> DRAIN for 4 cycles with IFID_Flush = 1, then Drained = 1. Deassert Halt -> RUN, and the PC resumes at the held address.
- PCSrc = 1 during DRAIN cycle 2 -> PCWrite = 1, Redirect = 3; HALTED is reached 4 cycles after that point. Assert Reset mid-DRAIN -> immediate RUN-reset outputs, counters = 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard/sequencing controller for a 5-stage MIPS pipeline
// (IF/ID/EX/MEM/WB) that has no forwarding network. Branches resolve in MEM,
// jr resolves in EX, j/jal resolve in ID. The block produces the PC and
// pipeline-register load/flush controls for RAW stalls, control redirects and
// a halt/drain sequence. It also keeps saturating stall/flush statistics and
// a sticky stall watchdog.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_id_rs/i_id_rt  source register fields of the instruction in ID
//   i_id_uses_rs/rt  ID instruction actually reads rs / rt
//   i_ex_reg_write   EX instruction writes the register file
//   i_ex_write_reg   EX destination register (after RegDst mux)
//   i_m_reg_write    MEM instruction writes the register file
//   i_m_write_reg    MEM destination register
//   i_id_jump        j/jal decoded in ID
//   i_ex_jr          jr in EX
//   i_pc_src         branch taken, resolved in MEM
//   i_halt           level request to drain and hold the pipeline
//   o_pc_write       PC load enable
//   o_ifid_write     IF/ID load enable
//   o_ifid_flush     load a bubble into IF/ID
//   o_idex_flush     load a bubble into ID/EX
//   o_exmem_flush    load a bubble into EX/MEM
//   o_redirect       PC source: 0 PC+4, 1 jump, 2 jr, 3 branch
//   o_drained        pipeline empty and held
//   o_hazard_err     sticky watchdog flag (consecutive stall limit reached)
//   o_stall_count    saturating count of RAW-stall cycles
//   o_flush_count    saturating count of redirect cycles
//
// State      | meaning
// -----------+-----------------------------------------------------------------
// ST_RUN     | normal operation, stall/redirect priority rules apply
// ST_DRAIN   | fetch frozen, bubbles fed into IF/ID until older work retires
// ST_HALTED  | pipeline empty and held until Halt drops
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_STALL    = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rs,
    input  logic        i_id_uses_rt,
    input  logic        i_ex_reg_write,
    input  logic [4:0]  i_ex_write_reg,
    input  logic        i_m_reg_write,
    input  logic [4:0]  i_m_write_reg,
    input  logic        i_id_jump,
    input  logic        i_ex_jr,
    input  logic        i_pc_src,
    input  logic        i_halt,
    output logic        o_pc_write,
    output logic        o_ifid_write,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic        o_exmem_flush,
    output logic [1:0]  o_redirect,
    output logic        o_drained,
    output logic        o_hazard_err,
    output logic [31:0] o_stall_count,
    output logic [31:0] o_flush_count
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int SW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(MAX_STALL);
    localparam logic [SW-1:0] STALL_ONE  = SW'(1);

    localparam logic [1:0] RD_PC4    = 2'd0;
    localparam logic [1:0] RD_JUMP   = 2'd1;
    localparam logic [1:0] RD_JR     = 2'd2;
    localparam logic [1:0] RD_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_drain_cnt;
    logic [DW-1:0]   w_drain_nxt;
    logic [SW-1:0]   r_stall_run;
    logic            r_hazard_err;
    logic [31:0]     r_stall_count;
    logic [31:0]     r_flush_count;

    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_raw;
    logic            w_stall_cyc;
    logic            w_redirect_cyc;

    logic            w_pc_write;
    logic            w_ifid_write;
    logic            w_ifid_flush;
    logic            w_idex_flush;
    logic            w_exmem_flush;
    logic [1:0]      w_redirect;
    logic            w_drained;

    // WB is not compared: the register file writes in the first half cycle,
    // so an ID read in the same cycle already sees the value.
    assign w_rs_hit = i_id_uses_rs && (i_id_rs != 5'd0) &&
                      ((i_ex_reg_write && (i_id_rs == i_ex_write_reg)) ||
                       (i_m_reg_write  && (i_id_rs == i_m_write_reg)));

    assign w_rt_hit = i_id_uses_rt && (i_id_rt != 5'd0) &&
                      ((i_ex_reg_write && (i_id_rt == i_ex_write_reg)) ||
                       (i_m_reg_write  && (i_id_rt == i_m_write_reg)));

    assign w_raw = w_rs_hit || w_rt_hit;

    // -------------------------------------------------------------------------
    // Next state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_redirect    = RD_PC4;
        w_drained     = 1'b0;
        w_stall_cyc   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_pc_src) begin
                    // A taken branch squashes everything younger than MEM,
                    // including any stalled instruction in ID.
                    w_redirect    = RD_BRANCH;
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_exmem_flush = 1'b1;
                end else if (i_ex_jr) begin
                    w_redirect   = RD_JR;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_raw) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_idex_flush = 1'b1;
                    w_stall_cyc  = 1'b1;
                end else if (i_id_jump) begin
                    // The jump itself advances into EX; only the
                    // wrong-path fetch behind it is squashed.
                    w_redirect   = RD_JUMP;
                    w_ifid_flush = 1'b1;
                end else if (i_halt) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end
            end

            ST_DRAIN: begin
                // PC is frozen on the first unexecuted instruction while
                // bubbles follow the older instructions out of the pipe.
                w_pc_write   = 1'b0;
                w_ifid_flush = 1'b1;
                if (i_pc_src) begin
                    w_pc_write    = 1'b1;
                    w_redirect    = RD_BRANCH;
                    w_idex_flush  = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_drain_nxt   = DRAIN_LOAD;
                end else if (i_ex_jr) begin
                    w_pc_write   = 1'b1;
                    w_redirect   = RD_JR;
                    w_idex_flush = 1'b1;
                    w_drain_nxt  = DRAIN_LOAD;
                end else if (w_raw) begin
                    // Keep the stalled ID instruction; it must still retire.
                    w_ifid_write = 1'b0;
                    w_ifid_flush = 1'b0;
                    w_idex_flush = 1'b1;
                    w_stall_cyc  = 1'b1;
                end else begin
                    if (i_id_jump) begin
                        w_pc_write = 1'b1;
                        w_redirect = RD_JUMP;
                    end
                    if (r_drain_cnt <= DRAIN_ONE) begin
                        w_state_nxt = ST_HALTED;
                        w_drain_nxt = '0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - DRAIN_ONE;
                    end
                end
            end

            ST_HALTED: begin
                w_pc_write   = 1'b0;
                w_ifid_flush = 1'b1;
                // Drained drops in the same cycle Halt is seen low.
                w_drained    = i_halt;
                if (!i_halt) begin
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
                w_drain_nxt = '0;
            end
        endcase

        // While reset is held everything is squashed and nothing loads
        // except the bubbles.
        if (i_reset) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_redirect    = RD_PC4;
            w_drained     = 1'b0;
        end
    end

    assign w_redirect_cyc = (w_redirect != RD_PC4);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall_cyc && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_redirect_cyc && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall watchdog: run length of consecutive stall cycles. The run counter
    // holds while HALTED since no counters move in that state.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_run  <= '0;
            r_hazard_err <= 1'b0;
        end else begin
            if (w_stall_cyc) begin
                if (r_stall_run < STALL_MAX) begin
                    r_stall_run <= r_stall_run + STALL_ONE;
                end
                if ((r_stall_run + STALL_ONE) >= STALL_MAX) begin
                    r_hazard_err <= 1'b1;
                end
            end else if (r_state != ST_HALTED) begin
                r_stall_run <= '0;
            end
        end
    end

    assign o_pc_write    = w_pc_write;
    assign o_ifid_write  = w_ifid_write;
    assign o_ifid_flush  = w_ifid_flush;
    assign o_idex_flush  = w_idex_flush;
    assign o_exmem_flush = w_exmem_flush;
    assign o_redirect    = w_redirect;
    assign o_drained     = w_drained;
    assign o_hazard_err  = r_hazard_err;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule
